// File: rtl/load_store_unit.sv
// Data-memory initiator for the non-pipelined core: one aligned
// 64-bit access per load/store over a req/gnt/rvalid handshake.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [63:0] ALUResult,
    input  logic [63:0] ReadData2,
    output logic [63:0] ReadData,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  f3_q;
    logic [2:0]  off_q;

    logic        op;
    logic        misal;
    logic        illegal;
    logic [2:0]  off;
    logic [7:0]  base;
    logic [7:0]  be;
    logic [63:0] bemask;
    logic [63:0] wdata;
    logic [63:0] rsh;
    logic [63:0] ext;

    assign op    = MemRead | MemWrite;
    assign stall = ((state == IDLE) & op) | (state == REQ) | (state == WAIT);

    // Decode size, legality and lane placement of the incoming op
    always_comb begin
        off = ALUResult[2:0];
        unique case (funct3[1:0])
            2'b00: begin
                base  = 8'h01;
                misal = 1'b0;
            end
            2'b01: begin
                base  = 8'h03;
                misal = off[0];
            end
            2'b10: begin
                base  = 8'h0F;
                misal = |off[1:0];
            end
            default: begin
                base  = 8'hFF;
                misal = |off;
            end
        endcase
        be      = base << off;
        illegal = (MemRead & MemWrite)
                | (MemRead & (funct3 == 3'b111))
                | (MemWrite & funct3[2])
                | misal;
        for (int i = 0; i < 8; i++) begin
            bemask[8*i +: 8] = {8{be[i]}};
        end
        wdata = (ReadData2 << {off, 3'b000}) & bemask;
    end

    // Pull the addressed bytes down and extend them to 64 bits
    always_comb begin
        rsh = mem_rdata >> {off_q, 3'b000};
        unique case (f3_q)
            3'b000:  ext = {{56{rsh[7]}}, rsh[7:0]};
            3'b001:  ext = {{48{rsh[15]}}, rsh[15:0]};
            3'b010:  ext = {{32{rsh[31]}}, rsh[31:0]};
            3'b100:  ext = {56'd0, rsh[7:0]};
            3'b101:  ext = {48'd0, rsh[15:0]};
            3'b110:  ext = {32'd0, rsh[31:0]};
            default: ext = rsh;
        endcase
    end

    // Access sequencer with registered bus and completion outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            f3_q      <= 3'd0;
            off_q     <= 3'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 64'd0;
            mem_wdata <= 64'd0;
            mem_be    <= 8'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            ReadData  <= 64'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (op) begin
                        ReadData <= 64'd0;
                        if (illegal) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= MemWrite;
                            mem_addr  <= {ALUResult[63:3], 3'b000};
                            mem_wdata <= MemWrite ? wdata : 64'd0;
                            mem_be    <= be;
                            f3_q      <= funct3;
                            off_q     <= off;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                        cnt     <= 8'd0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b0;
                        if (!mem_we) begin
                            ReadData <= ext;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (cnt == 8'(TIMEOUT - 1)) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            err      <= 1'b1;
                            ReadData <= 64'd0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    err      <= 1'b0;
                    ReadData <= 64'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random accesses checked
// every cycle against a byte-level model of the access rules.
module tb_load_store_unit;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [63:0] ALUResult, ReadData2;
    logic [63:0] ReadData;
    logic        stall, done, err;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [63:0] mem_rdata;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .ALUResult(ALUResult),
        .ReadData2(ReadData2), .ReadData(ReadData),
        .stall(stall), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        chk_en = 1'b0;
    logic        exp_stall, exp_done, exp_err, exp_req, exp_chk_rd;
    logic        exp_we;
    logic [63:0] exp_addr, exp_wdata, exp_rdata;
    logic [7:0]  exp_be;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    // Byte-by-byte statement of what an access must look like
    function automatic void model(
        input  logic        rd, wr,
        input  logic [2:0]  f3,
        input  logic [63:0] addr, wd, rdata,
        output logic        ill,
        output logic [63:0] eaddr,
        output logic [7:0]  ebe,
        output logic [63:0] ewd, erd
    );
        int n, off;
        n   = 1 << f3[1:0];
        off = int'(addr % 64'd8);
        ill = (rd && wr) || (rd && f3 == 3'd7) || (wr && f3 >= 3'd4)
            || (off % n != 0);
        eaddr = addr - 64'(off);
        ebe = '0;
        ewd = '0;
        erd = '0;
        if (!ill) begin
            for (int i = 0; i < n; i++) begin
                ebe[off+i] = 1'b1;
                if (wr) ewd[8*(off+i) +: 8] = wd[8*i +: 8];
                else    erd[8*i +: 8] = rdata[8*(off+i) +: 8];
            end
            if (rd && !f3[2] && n < 8 && erd[8*n-1]) begin
                for (int j = n; j < 8; j++) erd[8*j +: 8] = 8'hFF;
            end
        end
    endfunction

    // Single compare point for all DUT outputs
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", {63'd0, stall}, {63'd0, exp_stall});
            chk("done", {63'd0, done}, {63'd0, exp_done});
            chk("err", {63'd0, err}, {63'd0, exp_err});
            chk("mem_req", {63'd0, mem_req}, {63'd0, exp_req});
            if (exp_req) begin
                chk("mem_we", {63'd0, mem_we}, {63'd0, exp_we});
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_be", {56'd0, mem_be}, {56'd0, exp_be});
                chk("mem_wdata", mem_wdata, exp_wdata);
            end
            if (exp_chk_rd) chk("ReadData", ReadData, exp_rdata);
        end
    end

    task automatic noop();
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        mem_gnt    = 1'($urandom);
        mem_rvalid = 1'($urandom);
        mem_rdata  = {$urandom, $urandom};
        exp_stall  = 1'b0;
        exp_done   = 1'b0;
        exp_err    = 1'b0;
        exp_req    = 1'b0;
        exp_chk_rd = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // rv < 0: memory never answers. abort_k >= 0: reset in that cycle.
    task automatic run_op(
        input logic rd, wr, input logic [2:0] f3,
        input logic [63:0] addr, wd, input int gd, input int rv,
        input logic [63:0] rdata, input int abort_k
    );
        logic ill;
        logic [63:0] ea, ewd, erd;
        logic [7:0] ebe;
        int w, last, rk;
        model(rd, wr, f3, addr, wd, rdata, ill, ea, ebe, ewd, erd);
        MemRead   = rd;
        MemWrite  = wr;
        funct3    = f3;
        ALUResult = addr;
        ReadData2 = wd;
        exp_we    = wr;
        exp_addr  = ea;
        exp_be    = ebe;
        exp_wdata = ewd;
        w    = (rv < 0) ? TO : rv + 1;
        rk   = gd + 2 + rv;
        last = ill ? 1 : gd + 2 + w;
        for (int k = 0; k <= last; k++) begin
            exp_stall  = (k < last);
            exp_done   = (k == last);
            exp_err    = (k == last) && (ill || rv < 0);
            exp_req    = !ill && k >= 1 && k <= gd + 1;
            exp_chk_rd = (k == last) && !ill;
            exp_rdata  = (rv < 0) ? 64'd0 : erd;
            mem_rdata  = {$urandom, $urandom};
            if (!ill && k > gd + 1 && k < last) begin
                mem_gnt    = 1'b0;
                mem_rvalid = (rv >= 0 && k == rk);
                if (k == rk) mem_rdata = rdata;
            end else begin
                mem_gnt    = exp_req ? (k == gd + 1) : 1'($urandom);
                mem_rvalid = 1'($urandom);
            end
            if (k == abort_k) begin
                chk_en = 1'b0;
                #1;
                reset    = 1'b1;
                MemRead  = 1'b0;
                MemWrite = 1'b0;
                #1;
                chk("rst_req", {63'd0, mem_req}, 64'd0);
                chk("rst_done", {63'd0, done}, 64'd0);
                chk("rst_err", {63'd0, err}, 64'd0);
                chk("rst_rdata", ReadData, 64'd0);
                chk("rst_stall", {63'd0, stall}, 64'd0);
                #1;
                reset = 1'b0;
                @(posedge clk);
                #1;
                chk_en = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    logic        m_ill;
    logic [63:0] m_a, m_w, m_r;
    logic [7:0]  m_be;

    initial begin
        reset = 1'b1;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        funct3 = 3'd0;
        ALUResult = 64'd0;
        ReadData2 = 64'd0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 64'd0;
        #2;
        chk("reset_req", {63'd0, mem_req}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_err", {63'd0, err}, 64'd0);
        chk("reset_stall", {63'd0, stall}, 64'd0);
        chk("reset_be", {56'd0, mem_be}, 64'd0);
        chk("reset_addr", mem_addr, 64'd0);
        chk("reset_wdata", mem_wdata, 64'd0);
        chk("reset_rdata", ReadData, 64'd0);

        // Pin the model on hand-worked cases
        model(1, 0, 3'b011, 64'h40, 0, 64'h1122334455667788,
              m_ill, m_a, m_be, m_w, m_r);
        chk("pin_ld_be", {56'd0, m_be}, 64'hFF);
        chk("pin_ld_rd", m_r, 64'h1122334455667788);
        model(1, 0, 3'b000, 64'h43, 0, 64'h5566778880AABBCC,
              m_ill, m_a, m_be, m_w, m_r);
        chk("pin_lb_be", {56'd0, m_be}, 64'h08);
        chk("pin_lb_addr", m_a, 64'h40);
        chk("pin_lb_rd", m_r, 64'hFFFFFFFFFFFFFF80);
        model(1, 0, 3'b100, 64'h43, 0, 64'h5566778880AABBCC,
              m_ill, m_a, m_be, m_w, m_r);
        chk("pin_lbu_rd", m_r, 64'h80);
        model(0, 1, 3'b001, 64'h06, 64'hABCD, 0,
              m_ill, m_a, m_be, m_w, m_r);
        chk("pin_sh_be", {56'd0, m_be}, 64'hC0);
        chk("pin_sh_wd", m_w, 64'hABCD000000000000);
        model(1, 0, 3'b010, 64'h42, 0, 0, m_ill, m_a, m_be, m_w, m_r);
        chk("pin_lw_ill", {63'd0, m_ill}, 64'd1);

        #10;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        run_op(1, 0, 3'b011, 64'h40, 0, 0, 0, 64'h1122334455667788, -1);
        run_op(1, 0, 3'b000, 64'h43, 0, 0, 1, 64'h5566778880AABBCC, -1);
        run_op(1, 0, 3'b100, 64'h43, 0, 1, 0, 64'h5566778880AABBCC, -1);
        run_op(0, 1, 3'b001, 64'h06, 64'hABCD, 0, 0, 0, -1);
        run_op(1, 0, 3'b010, 64'h42, 0, 0, 0, 0, -1);
        run_op(1, 1, 3'b011, 64'h40, 0, 0, 0, 0, -1);
        run_op(1, 0, 3'b111, 64'h40, 0, 0, 0, 0, -1);
        run_op(0, 1, 3'b100, 64'h40, 0, 0, 0, 0, -1);
        run_op(0, 1, 3'b011, 64'h44, 0, 0, 0, 0, -1);
        run_op(1, 0, 3'b011, 64'h80, 0, 4, -1, 0, -1);
        run_op(1, 0, 3'b001, 64'h8A, 0, 0, 2, 64'h0000_8001_0000_0000, -1);
        run_op(0, 1, 3'b010, 64'h1C, 64'hDEADBEEF, 2, -1, 0, -1);
        noop();
        run_op(1, 0, 3'b011, 64'h100, 0, 1, 5, 64'h1, 4);
        run_op(1, 0, 3'b110, 64'h104, 0, 3, 0, 64'hFFFF_FFFF_0000_0000, 1);
        run_op(1, 0, 3'b010, 64'h104, 0, 0, 0, 64'h8765_4321_0000_0000, 3);
        run_op(1, 0, 3'b010, 64'h104, 0, 0, 0, 64'h8765_4321_0000_0000, -1);

        for (int t = 0; t < 300; t++) begin
            logic rd, wr;
            logic [2:0] f3;
            logic [63:0] a;
            int n;
            if ($urandom_range(0, 9) == 0) begin
                noop();
                continue;
            end
            rd = ($urandom_range(0, 9) < 6);
            wr = !rd || ($urandom_range(0, 29) == 0);
            if (rd && !wr) f3 = ($urandom_range(0, 19) == 0) ? 3'd7
                              : 3'($urandom_range(0, 6));
            else f3 = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(4, 7))
                    : 3'($urandom_range(0, 3));
            n = 1 << f3[1:0];
            a = {$urandom, $urandom};
            if ($urandom_range(0, 4) != 0) a = a & ~64'(n - 1);
            run_op(rd, wr, f3, a, {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   {$urandom, $urandom}, -1);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
